iterative_shifter: RTL and testbench

//  Parametrised multi-cycle shifter for the ALU shift path: SLL, SRA, ROR and SRL on a WIDTH-bit

---
 rtl/iterative_shifter.sv | 123 ++++++++++++
 tb/tb_iterative_shifter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_shifter.sv
// iterative_shifter: multi-cycle SLL/SRA/ROR/SRL, at most STEP bits per cycle.
// Valid/ready on both sides; zero/neg flags follow the result register.
module iterative_shifter #(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 4,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_neg
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_SRL = 2'b11;

  localparam logic [AW-1:0] STEP_A = AW'(STEP);
  localparam logic [AW:0]   WIDTH_A = (AW+1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       mode_q;
  logic [AW-1:0]    rem_q;

  logic [AW-1:0]    step_amt;
  logic [AW:0]      rot_lsh;
  logic [WIDTH-1:0] step_res;
  logic             is_sll;
  logic             is_sra;
  logic             is_ror;
  logic             is_srl;

  assign is_sll = (mode_q == MODE_SLL);
  assign is_sra = (mode_q == MODE_SRA);
  assign is_ror = (mode_q == MODE_ROR);
  assign is_srl = (mode_q == MODE_SRL);

  assign step_amt = (rem_q > STEP_A) ? STEP_A : rem_q;
  assign rot_lsh  = WIDTH_A - {1'b0, step_amt};

  // One partial step; the sign bit is preserved by SRA so refilling from
  // the current MSB is the same as refilling from the original operand.
  always_comb begin
    step_res = data_q;
    unique case (1'b1)
      is_sll:  step_res = data_q << step_amt;
      is_srl:  step_res = data_q >> step_amt;
      is_sra:  step_res = $unsigned($signed(data_q) >>> step_amt);
      is_ror:  step_res = (data_q >> step_amt)
                        | (data_q << rot_lsh);
      default: step_res = data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      mode_q    <= MODE_SLL;
      rem_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            mode_q   <= in_mode;
            rem_q    <= in_amt;
            in_ready <= 1'b0;
            if (in_amt == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= step_res;
          rem_q  <= rem_q - step_amt;
          if (rem_q == step_amt) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = data_q;
  assign out_zero = (data_q == '0);
  assign out_neg  = data_q[WIDTH-1];

endmodule

// File: tb/tb_iterative_shifter.sv
// tb_iterative_shifter: vector table, corner sequences and random sweep
// against a bit-level reference model.
module tb_iterative_shifter;

  localparam int W = 16;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [3:0]    in_amt;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zero;
  logic          out_neg;

  int n_tests = 0;
  int n_fail  = 0;

  iterative_shifter #(.WIDTH(W), .STEP(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [3:0]   amt;
    logic [1:0]   mode;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bit-by-bit definition of each shift, independent of step size
  function automatic logic [W-1:0] model(input logic [W-1:0] d,
                                         input int amt,
                                         input logic [1:0] mode);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      int j;
      j = i + amt;
      case (mode)
        2'b00:   r[i] = (i >= amt) ? d[i-amt] : 1'b0;
        2'b11:   r[i] = (j < W) ? d[j] : 1'b0;
        2'b01:   r[i] = (j < W) ? d[j] : d[W-1];
        default: r[i] = d[j % W];
      endcase
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] d, input logic [3:0] amt,
                       input logic [1:0] mode,
                       output logic [W-1:0] res, output logic z,
                       output logic n, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_data  = d;
    in_amt   = amt;
    in_mode  = mode;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_amt   = 4'($urandom);
    in_mode  = 2'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    res = out_data;
    z   = out_zero;
    n   = out_neg;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] exp;
    logic         z;
    logic         n;
    int           lat;
    logic [3:0]   amt;
    logic [1:0]   mode;
    logic [W-1:0] d;

    vt[0]  = '{16'h00FF, 4'd4,  2'b00, 16'h0FF0, 2};
    vt[1]  = '{16'h8001, 4'd15, 2'b01, 16'hFFFF, 5};
    vt[2]  = '{16'h8000, 4'd15, 2'b11, 16'h0001, 5};
    vt[3]  = '{16'h0001, 4'd1,  2'b10, 16'h8000, 2};
    vt[4]  = '{16'h1234, 4'd8,  2'b10, 16'h3412, 3};
    vt[5]  = '{16'h1234, 4'd0,  2'b00, 16'h1234, 1};
    vt[6]  = '{16'h0001, 4'd15, 2'b00, 16'h8000, 5};
    vt[7]  = '{16'h8000, 4'd1,  2'b00, 16'h0000, 2};
    vt[8]  = '{16'h7FF0, 4'd5,  2'b01, 16'h03FF, 3};
    vt[9]  = '{16'h8421, 4'd4,  2'b10, 16'h1842, 2};
    vt[10] = '{16'h8000, 4'd8,  2'b01, 16'hFF80, 3};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_amt = '0;
    in_mode = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd1);
    check("rst_out_neg", 32'(out_neg), 32'd0);

    foreach (vt[i]) begin
      do_op(vt[i].d, vt[i].amt, vt[i].mode, res, z, n, lat);
      check($sformatf("vec%0d_data", i), 32'(res), 32'(vt[i].exp));
      check($sformatf("vec%0d_model", i), 32'(res),
            32'(model(vt[i].d, int'(vt[i].amt), vt[i].mode)));
      check($sformatf("vec%0d_zero", i), 32'(z), 32'(vt[i].exp == '0));
      check($sformatf("vec%0d_neg", i), 32'(n), 32'(vt[i].exp[W-1]));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
    end

    // Result held under back-pressure; extra requests ignored
    in_data = 16'h1234;
    in_amt = 4'd0;
    in_mode = 2'b00;
    in_valid = 1'b1;
    tick();
    in_data = 16'hBEEF;
    in_amt = 4'd3;
    in_mode = 2'b11;
    for (int k = 0; k < 3; k++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'h1234);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release_ready", 32'(in_ready), 32'd1);
    check("hold_release_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a long shift discards the operation
    in_data = 16'h8000;
    in_amt = 4'd15;
    in_mode = 2'b11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end
    do_op(16'h00F0, 4'd6, 2'b10, res, z, n, lat);
    check("after_rst_data", 32'(res), 32'hC003);
    check("after_rst_lat", 32'(lat), 32'd3);

    // Reset while a result waits in DONE
    in_data = 16'h5555;
    in_amt = 4'd0;
    in_mode = 2'b00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("done_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("donerst_valid", 32'(out_valid), 32'd0);
    check("donerst_ready", 32'(in_ready), 32'd1);

    for (int t = 0; t < 300; t++) begin
      d    = W'($urandom);
      amt  = 4'($urandom_range(0, 15));
      mode = 2'($urandom);
      if (t % 16 == 0) d = '0;
      exp = model(d, int'(amt), mode);
      do_op(d, amt, mode, res, z, n, lat);
      check($sformatf("rnd%0d_data m%0d a%0d", t, mode, amt),
            32'(res), 32'(exp));
      check($sformatf("rnd%0d_zero", t), 32'(z), 32'(exp == '0));
      check($sformatf("rnd%0d_neg", t), 32'(n), 32'(exp[W-1]));
      check($sformatf("rnd%0d_lat", t), 32'(lat),
            32'(1 + (int'(amt) + S - 1) / S));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
